// File: rtl/boreal_ledger_export_pkg.sv
// Shared definitions for the audit-ledger export drain.
//   LEDGER_ENTRY_W : width of one ledger entry
//   LEDGER_BEATS   : stream beats per entry
//   BEAT_W         : stream beat width
//   ledexp_state_e : export FSM state codes
package boreal_ledger_export_pkg;

  localparam int LEDGER_ENTRY_W = 256;
  localparam int LEDGER_BEATS   = 8;
  localparam int BEAT_W         = 32;

  typedef enum logic [1:0] {
    LEDEXP_S_IDLE   = 2'd0,
    LEDEXP_S_REQ    = 2'd1,
    LEDEXP_S_WAIT   = 2'd2,
    LEDEXP_S_STREAM = 2'd3
  } ledexp_state_e;

endpackage

// File: rtl/boreal_ledger_export_ser.sv
// Entry serializer: captures one 256-bit ledger entry and plays it out as
// eight 32-bit beats on a valid/ready stream, lowest word first.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : capture data_i and start streaming from beat 0
//   data_i       : ledger entry to serialize
//   ready_i      : stream sink ready
//   valid_o      : stream beat valid
//   data_o       : current beat word (zero when idle)
//   last_o       : high while the final beat is presented
//   done_o       : one-cycle pulse on the final beat's handshake
module boreal_ledger_export_ser
  import boreal_ledger_export_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [LEDGER_ENTRY_W-1:0] data_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [BEAT_W-1:0]         data_o,
  output logic                      last_o,
  output logic                      done_o
);

  logic [LEDGER_ENTRY_W-1:0] buf_q, buf_d;
  logic [2:0]                beat_q, beat_d;
  logic                      active_q, active_d;
  logic [BEAT_W-1:0]         word [LEDGER_BEATS];

  for (genvar gi = 0; gi < LEDGER_BEATS; gi++) begin : g_word
    assign word[gi] = buf_q[gi*BEAT_W +: BEAT_W];
  end

  always_comb begin
    buf_d    = buf_q;
    beat_d   = beat_q;
    active_d = active_q;
    if (load_i) begin
      buf_d    = data_i;
      beat_d   = 3'd0;
      active_d = 1'b1;
    end else if (active_q && ready_i) begin
      // The 3-bit counter wraps back to 0 after the final beat.
      beat_d = beat_q + 3'd1;
      if (beat_q == 3'(LEDGER_BEATS - 1)) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      beat_q   <= 3'd0;
      active_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      beat_q   <= beat_d;
      active_q <= active_d;
    end
  end

  // Beat word and last are functions of registered state only, so they hold
  // steady while the sink stalls.
  assign valid_o = active_q;
  assign data_o  = active_q ? word[beat_q] : '0;
  assign last_o  = active_q && (beat_q == 3'(LEDGER_BEATS - 1));
  assign done_o  = active_q && ready_i && last_o;

endmodule

// File: rtl/boreal_ledger_export.sv
// Audit-ledger export drain. Follows the ledger write count with a read
// pointer, fetches one entry at a time and streams it as eight 32-bit beats.
// If the ledger has wrapped past unread entries the pointer jumps to the
// oldest intact entry and a sticky overrun flag is raised.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable       : export enable (level)
//   clr_overrun  : pulse clearing the overrun flag (set wins)
//   led_idx      : ledger total-written count, wraps mod 2^32
//   led_rd_req   : one-cycle ledger read strobe
//   led_rd_addr  : ledger read address (low bits of rd_ptr)
//   led_rd_data  : ledger entry, valid the cycle after led_rd_req
//   m_valid/m_ready/m_data/m_last : 32-bit output stream
//   rd_ptr       : entries consumed (exported or skipped)
//   overrun      : sticky flag, entries lost to ledger wrap
module boreal_ledger_export
  import boreal_ledger_export_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clr_overrun,
  input  logic [31:0]               led_idx,
  output logic                      led_rd_req,
  output logic [AW-1:0]             led_rd_addr,
  input  logic [LEDGER_ENTRY_W-1:0] led_rd_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [BEAT_W-1:0]         m_data,
  output logic                      m_last,
  output logic [31:0]               rd_ptr,
  output logic                      overrun
);

  ledexp_state_e state_q, state_d;
  logic [31:0]   rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   pending;
  logic          ovr_set;
  logic          ser_load;
  logic          ser_done;

  // Modulo-2^32 difference stays correct across led_idx wrap.
  assign pending = led_idx - rd_ptr_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    ovr_set  = 1'b0;
    case (state_q)
      LEDEXP_S_IDLE: begin
        // pending == DEPTH still has the oldest entry intact; only beyond
        // that has the ledger overwritten something unread.
        if (pending > 32'(DEPTH)) begin
          rd_ptr_d = led_idx - 32'(DEPTH);
          ovr_set  = 1'b1;
        end else if (enable && (pending != 32'd0)) begin
          state_d = LEDEXP_S_REQ;
        end
      end
      LEDEXP_S_REQ:  state_d = LEDEXP_S_WAIT;
      LEDEXP_S_WAIT: state_d = LEDEXP_S_STREAM;
      LEDEXP_S_STREAM: begin
        if (ser_done) begin
          rd_ptr_d = rd_ptr_q + 32'd1;
          state_d  = LEDEXP_S_IDLE;
        end
      end
      default: state_d = LEDEXP_S_IDLE;
    endcase
    overrun_d = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LEDEXP_S_IDLE;
      rd_ptr_q  <= 32'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign led_rd_req  = (state_q == LEDEXP_S_REQ);
  assign led_rd_addr = rd_ptr_q[AW-1:0];
  // Ledger data arrives during WAIT; capture it there.
  assign ser_load    = (state_q == LEDEXP_S_WAIT);
  assign rd_ptr      = rd_ptr_q;
  assign overrun     = overrun_q;

  boreal_ledger_export_ser u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .data_i  (led_rd_data),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .last_o  (m_last),
    .done_o  (ser_done)
  );

endmodule
